setting_bank: RTL and testbench

SETTING_BANK -- requirements
Module: setting_bank

---
 rtl/setting_pkg.sv | 26 ++
 rtl/setting_clamp.sv | 27 ++
 rtl/setting_bank.sv | 123 ++++++++++++
 tb/tb_setting_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/setting_pkg.sv
// Shared FSM encoding, default geometry and reset/limit tables for the settings bank.
// Declarations only: no latency, no flow control.
package setting_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int N_FIELD_DEF = 6;
  localparam int DATA_W_DEF  = 8;

  localparam int PLAYER_COUNT   = 0;
  localparam int QUESTION_COUNT = 1;
  localparam int ANSWER_TIME    = 2;
  localparam int WIN_SCORE      = 3;
  localparam int SUCCESS_SCORE  = 4;
  localparam int FAIL_SCORE     = 5;

  // Field 0 sits in the least significant byte.
  localparam logic [47:0] DEFAULTS_DEF = {8'd1, 8'd1, 8'd3, 8'd10, 8'd5, 8'd2};
  localparam logic [47:0] MINS_DEF     = {8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
  localparam logic [47:0] MAXS_DEF     = {8'd15, 8'd15, 8'd99, 8'd99, 8'd15, 8'd4};

endpackage

// File: rtl/setting_clamp.sv
// Saturates a candidate setting into [min, max] and flags when it had to.
// Purely combinational; no flow control.
module setting_clamp
  import setting_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] min,
  input  logic [DATA_W-1:0] max,
  output logic [DATA_W-1:0] out,
  output logic              clamped_flag
);

  always_comb begin
    out          = value;
    clamped_flag = 1'b0;
    if (value < min) begin
      out          = min;
      clamped_flag = 1'b1;
    end else if (value > max) begin
      out          = max;
      clamped_flag = 1'b1;
    end
  end

endmodule

// File: rtl/setting_bank.sv
// Switch/button driven editor for a bank of clamped game settings.
// Write lands on the edge that sees the confirm rise; inputs are levels, no backpressure.
module setting_bank
  import setting_pkg::*;
#(
  parameter int                        N_FIELD  = N_FIELD_DEF,
  parameter int                        DATA_W   = DATA_W_DEF,
  parameter logic [N_FIELD*DATA_W-1:0] DEFAULTS = DEFAULTS_DEF,
  parameter logic [N_FIELD*DATA_W-1:0] MINS     = MINS_DEF,
  parameter logic [N_FIELD*DATA_W-1:0] MAXS     = MAXS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [23:0]                 sw,
  input  logic [4:0]                  bt,
  input  logic                        view,
  input  logic                        lock,
  output logic [N_FIELD*DATA_W-1:0]   fields,
  output logic [1:0]                  state,
  output logic [2:0]                  edit_idx,
  output logic                        commit,
  output logic                        clamped
);

  state_t            cur, nxt;
  logic [1:0]        bt_q;
  logic              confirm_rise, cancel_rise;
  logic              any_sel, sel_held, abort, do_write;
  logic [2:0]        first_idx, idx_nxt;
  logic [DATA_W-1:0] min_sel, max_sel, clamp_val;
  logic              clamp_flag;
  logic              unused_in;

  assign unused_in    = ^{sw, bt[4:2]};
  assign confirm_rise = bt[0] & ~bt_q[0];
  assign cancel_rise  = bt[1] & ~bt_q[1];
  assign sel_held     = sw[5'd22 - {2'b00, edit_idx}];
  assign state        = cur;

  // Walk from the highest index down so the lowest selected field wins.
  always_comb begin
    any_sel   = 1'b0;
    first_idx = '0;
    for (int i = N_FIELD - 1; i >= 0; i--) begin
      if (sw[22-i]) begin
        any_sel   = 1'b1;
        first_idx = 3'(i);
      end
    end
  end

  always_comb begin
    min_sel = '0;
    max_sel = '0;
    for (int i = 0; i < N_FIELD; i++) begin
      if (edit_idx == 3'(i)) begin
        min_sel = MINS[i*DATA_W +: DATA_W];
        max_sel = MAXS[i*DATA_W +: DATA_W];
      end
    end
  end

  setting_clamp #(.DATA_W(DATA_W)) u_clamp (
    .value        (sw[DATA_W-1:0]),
    .min          (min_sel),
    .max          (max_sel),
    .out          (clamp_val),
    .clamped_flag (clamp_flag)
  );

  always_comb begin
    nxt      = cur;
    idx_nxt  = edit_idx;
    do_write = 1'b0;
    abort    = ~sel_held | cancel_rise | view | lock;
    case (cur)
      ST_IDLE: begin
        if (!view && !lock && any_sel) begin
          nxt     = ST_EDIT;
          idx_nxt = first_idx;
        end
      end
      ST_EDIT: begin
        // Any abort condition overrides a simultaneous confirm.
        if (abort) begin
          nxt     = ST_IDLE;
          idx_nxt = '0;
        end else if (confirm_rise) begin
          nxt      = ST_COMMIT;
          do_write = 1'b1;
        end
      end
      default: begin
        nxt     = ST_IDLE;
        idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= ST_IDLE;
    else      cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edit_idx <= '0;
      bt_q     <= '0;
      commit   <= 1'b0;
      clamped  <= 1'b0;
      fields   <= DEFAULTS;
    end else begin
      edit_idx <= idx_nxt;
      bt_q     <= bt[1:0];
      commit   <= do_write;
      clamped  <= do_write & clamp_flag;
      for (int i = 0; i < N_FIELD; i++) begin
        if (do_write && edit_idx == 3'(i)) fields[i*DATA_W +: DATA_W] <= clamp_val;
      end
    end
  end

endmodule

// File: tb/tb_setting_bank.sv
// Randomised and directed checks of setting_bank against a field-array model.
module tb_setting_bank;
  import setting_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sw;
  logic [4:0]  bt;
  logic        view, lock;
  logic [47:0] fields;
  logic [1:0]  state;
  logic [2:0]  edit_idx;
  logic        commit, clamped;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  localparam int DEF [6] = '{2, 5, 10, 3, 1, 1};
  localparam int MN  [6] = '{2, 1, 1, 1, 0, 0};
  localparam int MX  [6] = '{4, 15, 99, 99, 15, 15};
  localparam logic [47:0] DEF_PACKED = 48'h0101030A0502;

  setting_bank dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .bt       (bt),
    .view     (view),
    .lock     (lock),
    .fields   (fields),
    .state    (state),
    .edit_idx (edit_idx),
    .commit   (commit),
    .clamped  (clamped)
  );

  always #5 clk = ~clk;

  // Model: per-field integers, the field being edited (-1 when none) and a commit flag.
  int m_f [6] = '{2, 5, 10, 3, 1, 1};
  int m_edit  = -1;
  bit m_commit = 1'b0;
  bit m_clamp  = 1'b0;
  bit [1:0] m_btq = 2'b00;

  always @(posedge clk or negedge rst) begin
    bit rc, rx;
    int v, pick;
    if (!rst) begin
      for (int i = 0; i < 6; i++) m_f[i] = DEF[i];
      m_edit = -1; m_commit = 1'b0; m_clamp = 1'b0; m_btq = 2'b00;
    end else begin
      rc = bt[0] && !m_btq[0];
      rx = bt[1] && !m_btq[1];
      if (m_commit) begin
        m_commit = 1'b0; m_clamp = 1'b0; m_edit = -1;
      end else if (m_edit < 0) begin
        if (!view && !lock) begin
          pick = -1;
          for (int i = 5; i >= 0; i--) if (sw[22-i]) pick = i;
          m_edit = pick;
        end
      end else if (!sw[22-m_edit] || rx || view || lock) begin
        m_edit = -1;
      end else if (rc) begin
        v = int'(sw[7:0]);
        m_clamp = (v < MN[m_edit]) || (v > MX[m_edit]);
        m_f[m_edit] = (v < MN[m_edit]) ? MN[m_edit] : (v > MX[m_edit]) ? MX[m_edit] : v;
        m_commit = 1'b1;
      end
      m_btq = bt[1:0];
    end
  end

  function automatic logic [47:0] model_fields();
    logic [47:0] p = '0;
    for (int i = 0; i < 6; i++) p[i*8 +: 8] = 8'(m_f[i]);
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_fields",   64'(fields),   64'(model_fields()));
      check("m_state",    64'(state),    m_commit ? 64'd2 : (m_edit >= 0 ? 64'd1 : 64'd0));
      check("m_edit_idx", 64'(edit_idx), (m_edit >= 0) ? 64'(m_edit) : 64'd0);
      check("m_commit",   64'(commit),   64'(m_commit));
      check("m_clamped",  64'(clamped),  64'(m_commit && m_clamp));
    end
  end

  function automatic logic [23:0] sel(input int i);
    logic [23:0] one = 24'd1;
    return one << (22 - i);
  endfunction

  // Drive just after the falling edge, return just after the rising edge that consumed it.
  task automatic step(input logic [23:0] s, input logic [4:0] b, input logic v, input logic l,
                      input logic r);
    @(negedge clk); #1;
    sw = s; bt = b; view = v; lock = l; rst = r;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [23:0] rs;
    logic [4:0]  rb;
    logic        rv, rl, rr;
    sw = '0; bt = '0; view = 1'b0; lock = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    step(24'd0, 5'd0, 0, 0, 1);
    check("rst_fields", 64'(fields), 64'(DEF_PACKED));
    check("rst_state",  64'(state),  64'd0);
    check("rst_commit", 64'(commit), 64'd0);
    chk_en = 1'b1;

    // Player count = 3, in range.
    step(sel(PLAYER_COUNT) | 24'd3, 5'd0, 0, 0, 1);
    check("pc_edit", 64'(state), 64'd1);
    step(sel(PLAYER_COUNT) | 24'd3, 5'd1, 0, 0, 1);
    check("pc_commit_state", 64'(state), 64'd2);
    check("pc_commit",       64'(commit), 64'd1);
    check("pc_clamped",      64'(clamped), 64'd0);
    check("pc_field",        64'(fields[7:0]), 64'd3);
    step(sel(PLAYER_COUNT) | 24'd3, 5'd1, 0, 0, 1);
    check("pc_pulse_end", 64'(commit), 64'd0);
    step(sel(PLAYER_COUNT) | 24'd3, 5'd1, 0, 0, 1);
    step(sel(PLAYER_COUNT) | 24'd3, 5'd1, 0, 0, 1);
    check("pc_no_recommit", 64'(state), 64'd1);
    step(24'd0, 5'd0, 0, 0, 1);

    // Out-of-range values saturate.
    step(sel(ANSWER_TIME) | 24'd200, 5'd0, 0, 0, 1);
    step(sel(ANSWER_TIME) | 24'd200, 5'd1, 0, 0, 1);
    check("at_field",   64'(fields[23:16]), 64'd99);
    check("at_clamped", 64'(clamped), 64'd1);
    step(24'd0, 5'd0, 0, 0, 1);
    step(24'd0, 5'd0, 0, 0, 1);
    step(sel(PLAYER_COUNT), 5'd0, 0, 0, 1);
    step(sel(PLAYER_COUNT), 5'd1, 0, 0, 1);
    check("pc_min_field",   64'(fields[7:0]), 64'd2);
    check("pc_min_clamped", 64'(clamped), 64'd1);
    step(24'd0, 5'd0, 0, 0, 1);
    step(24'd0, 5'd0, 0, 0, 1);

    // Priority and abort on select drop.
    step(sel(QUESTION_COUNT) | sel(WIN_SCORE) | 24'd9, 5'd0, 0, 0, 1);
    check("prio_idx", 64'(edit_idx), 64'd1);
    step(sel(WIN_SCORE) | 24'd9, 5'd0, 0, 0, 1);
    check("drop_state", 64'(state), 64'd0);
    step(24'd0, 5'd0, 0, 0, 1);
    check("drop_qc", 64'(fields[15:8]), 64'd5);

    // Lock with confirm, then cancel with confirm.
    step(sel(QUESTION_COUNT) | 24'd7, 5'd0, 0, 0, 1);
    step(sel(QUESTION_COUNT) | 24'd7, 5'd1, 0, 1, 1);
    check("lock_state",  64'(state), 64'd0);
    check("lock_commit", 64'(commit), 64'd0);
    step(24'd0, 5'd0, 0, 0, 1);
    step(sel(QUESTION_COUNT) | 24'd7, 5'd0, 0, 0, 1);
    step(sel(QUESTION_COUNT) | 24'd7, 5'd3, 0, 0, 1);
    check("cancel_commit", 64'(commit), 64'd0);
    check("cancel_fields", 64'(fields), 64'h010103630502);
    step(24'd0, 5'd0, 0, 0, 1);

    // Reset mid-edit.
    step(sel(SUCCESS_SCORE) | 24'd7, 5'd0, 0, 0, 1);
    check("pre_rst_state", 64'(state), 64'd1);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_rst_fields", 64'(fields), 64'(DEF_PACKED));
    check("async_rst_state",  64'(state), 64'd0);
    step(sel(SUCCESS_SCORE) | 24'd7, 5'd1, 0, 0, 0);
    check("held_rst_state", 64'(state), 64'd0);
    step(24'd0, 5'd0, 0, 0, 1);
    check("post_rst_fields", 64'(fields), 64'(DEF_PACKED));

    // Random phase, scored by the model every cycle.
    rs = '0; rb = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        rs[23:17] = '0;
        for (int k = 0; k < 6; k++) if ($urandom_range(0, 3) == 0) rs |= sel(k);
        if ($urandom_range(0, 7) == 0) rs[23] = 1'b1;
      end
      rs[16:0] = 17'($urandom);
      for (int k = 0; k < 5; k++) if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
      rv = ($urandom_range(0, 15) == 0);
      rl = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 299) != 0);
      step(rs, rb, rv, rl, rr);
    end
    step(24'd0, 5'd0, 0, 0, 1);
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
